spec_readout: RTL and testbench

- Reads accumulated power spectra back out of the spectrum DPRAM (port B) once accumulation is complete.
- Streams them to the downstream host/transfer FIFO with a valid/ready handshake.
- Sits between the spectrum accumulator's DPRAM and the output packer.
- Walks range bins 0..num_bins-1 and FFT indices 0..2^IDX_W-1 in order, hiding DPRAM read latency with a small credit-controlled output FIFO.

---
 rtl/spec_readout.sv | 144 ++++++++++++++
 tb/tb_spec_readout.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spec_readout.sv
// spec_readout: streams accumulated power spectra from DPRAM port B to a valid/ready sink
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         one-cycle pulse that begins a readout (ignored while busy)
//   num_bins      number of range bins to read, clamped to 2^BIN_W (0 = none)
//   rd_addr       DPRAM port-B address {bin, idx}
//   rd_en         DPRAM port-B read enable
//   rd_data       DPRAM data, valid RD_LAT cycles after rd_en
//   out_data      output word (FIFO head)
//   out_valid     output word valid
//   out_ready     downstream accept
//   out_bin_last  last word of a range bin
//   out_last      last word of the whole readout
//   busy          high from accepted start until done
//   done          one-cycle pulse after the final word is accepted
// Optional: define SPEC_RD_HEADER_EN to prefix each bin with a header word {16'hA5A5, bin}.
module spec_readout #(
   parameter int DATA_W     = 32,
   parameter int IDX_W      = 10,
   parameter int BIN_W      = 4,
   parameter int RD_LAT     = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [BIN_W:0]         num_bins,
   output logic [BIN_W+IDX_W-1:0] rd_addr,
   output logic                   rd_en,
   input  logic [DATA_W-1:0]      rd_data,
   output logic [DATA_W-1:0]      out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_bin_last,
   output logic                   out_last,
   output logic                   busy,
   output logic                   done
);
`ifdef SPEC_RD_HEADER_EN
   localparam bit HDR = 1'b1;
`else
   localparam bit HDR = 1'b0;
`endif
   localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;
   typedef struct packed {
      logic             v;
      logic             hdr;
      logic             bin_last;
      logic             last;
      logic [BIN_W-1:0] bin;
   } tag_t;
   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              bin_last;
      logic              last;
   } entry_t;
   state_t        state, state_nx;
   logic [BIN_W:0] nb, nb_in;
   logic [BIN_W-1:0] bin;
   logic [IDX_W-1:0] idx;
   logic          hdr_pend, done_z;
   tag_t          pipe [RD_LAT];
   entry_t        fifo [FIFO_DEPTH];
   entry_t        push_e;
   logic [PW-1:0] wp, rp;
   logic [CW-1:0] cnt, infl;
   logic          credit, issue, hdr_issue, push, pop, last_addr;
   // any request above 2^BIN_W has the top bit set, so it collapses to exactly 2^BIN_W
   assign nb_in = num_bins[BIN_W] ? {1'b1, {BIN_W{1'b0}}} : num_bins;
   always_comb begin
      infl = '0;
      for (int i = 0; i < RD_LAT; i++) infl = infl + CW'(pipe[i].v);
   end
   // occupancy counts words already queued plus those still in the read pipeline
   assign credit    = (cnt + infl) < CW'(FIFO_DEPTH);
   assign hdr_issue = state == ISSUE && credit && hdr_pend;
   assign issue     = state == ISSUE && credit && !hdr_pend;
   assign last_addr = {1'b0, bin} == nb - 1'b1 && &idx;
   assign rd_en     = issue;
   assign rd_addr   = {bin, idx};
   assign push      = pipe[RD_LAT-1].v;
   assign pop       = out_valid && out_ready;
   assign push_e    = '{data: pipe[RD_LAT-1].hdr ? DATA_W'({16'hA5A5, 16'(pipe[RD_LAT-1].bin)}) : rd_data,
                        bin_last: pipe[RD_LAT-1].bin_last, last: pipe[RD_LAT-1].last};
   assign out_valid    = cnt != '0;
   assign out_data     = out_valid ? fifo[rp].data : '0;
   assign out_bin_last = out_valid && fifo[rp].bin_last;
   assign out_last     = out_valid && fifo[rp].last;
   assign busy         = state != IDLE;
   assign done         = state == FINISH || done_z;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = start && nb_in != '0 ? ISSUE : IDLE;
         ISSUE:   state_nx = issue && last_addr ? DRAIN : ISSUE;
         // leave as soon as the final word is being accepted so done follows it by one cycle
         DRAIN:   state_nx = infl == '0 && (cnt == '0 || (cnt == CW'(1) && pop)) ? FINISH : DRAIN;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         nb       <= '0;
         bin      <= '0;
         idx      <= '0;
         hdr_pend <= 1'b0;
         done_z   <= 1'b0;
         wp       <= '0;
         rp       <= '0;
         cnt      <= '0;
         for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) fifo[i] <= '0;
      end else begin
         state  <= state_nx;
         done_z <= state == IDLE && start && nb_in == '0;
         if (state == IDLE && start) begin
            nb       <= nb_in;
            bin      <= '0;
            idx      <= '0;
            hdr_pend <= HDR;
         end
         if (issue) begin
            idx <= idx + 1'b1;
            if (&idx) begin
               bin      <= bin + 1'b1;
               hdr_pend <= HDR;
            end
         end
         if (hdr_issue) hdr_pend <= 1'b0;
         pipe[0] <= '{v: issue || hdr_issue, hdr: hdr_issue, bin_last: issue && &idx,
                      last: issue && last_addr, bin: bin};
         for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
         if (push) begin
            fifo[wp] <= push_e;
            wp       <= wp == PW'(FIFO_DEPTH - 1) ? '0 : wp + 1'b1;
         end
         if (pop) rp <= rp == PW'(FIFO_DEPTH - 1) ? '0 : rp + 1'b1;
         cnt <= cnt + CW'(push) - CW'(pop);
      end
   end
endmodule

// File: tb/tb_spec_readout.sv
// tb_spec_readout: scoreboard bench for spec_readout with a latency-2 DPRAM holding word = address
module tb_spec_readout;
   localparam int DATA_W = 32, IDX_W = 10, BIN_W = 4, RD_LAT = 2, FIFO_DEPTH = 4;
   localparam int NPTS = 1 << IDX_W;
`ifdef SPEC_RD_HEADER_EN
   localparam int H = 1;
`else
   localparam int H = 0;
`endif
   localparam int CAPN = 2100;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b1;
   logic [BIN_W:0] num_bins = '0;
   logic [BIN_W+IDX_W-1:0] rd_addr, a1, a2;
   logic rd_en, out_valid, out_bin_last, out_last, busy, done;
   logic [DATA_W-1:0] rd_data, out_data;
   spec_readout #(.DATA_W(DATA_W), .IDX_W(IDX_W), .BIN_W(BIN_W), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk(clk), .rst(rst), .start(start), .num_bins(num_bins), .rd_addr(rd_addr), .rd_en(rd_en),
      .rd_data(rd_data), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_bin_last(out_bin_last), .out_last(out_last), .busy(busy), .done(done));
   always #5 clk = ~clk;
   always @(posedge clk) begin
      a1 <= rd_addr;
      a2 <= a1;
   end
   assign rd_data = DATA_W'(a2);
   int tests = 0, fails = 0;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      tests++;
      if (act !== exp_v) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp_v);
      end
   endtask
   typedef struct { logic [31:0] d; logic bl; logic l; } exp_t;
   exp_t q[$];
   bit check_on = 0, mb = 0, dd = 0, hold = 0;
   logic [31:0] hold_data;
   int cyc = 0, xfers = 0, rd_issued = 0, start_cyc = 0, first_valid = -1, first_x = 0, last_x = 0;
   int dones = 0, rd_total = 0, ov_total = 0;
   logic [31:0] cap_d [CAPN];
   logic cap_bl [CAPN], cap_l [CAPN];
   always @(negedge clk) begin
      bit last_now, mb_n;
      exp_t e;
      int n;
      cyc++;
      last_now = 0;
      if (check_on) begin
         chk("busy", busy, mb);
         chk("done", done, dd);
         if (done) dones++;
         if (rd_en) rd_total++;
         if (out_valid) ov_total++;
         if (hold) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, hold_data);
         end
         if (rd_en === 1'b1) begin
            chk("rd_addr", rd_addr, rd_issued);
`ifndef SPEC_RD_HEADER_EN
            chk("credit", 32'(rd_issued - xfers < FIFO_DEPTH), 1);
`endif
            rd_issued++;
         end
         if (out_valid && first_valid < 0) first_valid = cyc;
         if (out_valid === 1'b1 && out_ready) begin
            if (q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL extra_word: got %h expected none", out_data);
            end else begin
               e = q.pop_front();
               chk("data", out_data, e.d);
               chk("bin_last", out_bin_last, e.bl);
               chk("last", out_last, e.l);
               last_now = q.size() == 0;
            end
            if (xfers < CAPN) begin
               cap_d[xfers]  = out_data;
               cap_bl[xfers] = out_bin_last;
               cap_l[xfers]  = out_last;
            end
            if (xfers == 0) first_x = cyc;
            last_x = cyc;
            xfers++;
         end
      end
      hold      = out_valid && !out_ready;
      hold_data = out_data;
      mb_n      = mb;
      if (start && !mb && num_bins != 0) begin
         n = num_bins > (1 << BIN_W) ? (1 << BIN_W) : int'(num_bins);
         q.delete();
         for (int b = 0; b < n; b++) begin
`ifdef SPEC_RD_HEADER_EN
            q.push_back('{32'hA5A5_0000 | b, 1'b0, 1'b0});
`endif
            for (int i = 0; i < NPTS; i++)
               q.push_back('{b * NPTS + i, i == NPTS - 1, b == n - 1 && i == NPTS - 1});
         end
         mb_n = 1;
         start_cyc = cyc;
         first_valid = -1;
         xfers = 0;
         rd_issued = 0;
      end else if (dd) mb_n = 0;
      dd = last_now || (start && !mb && num_bins == 0);
      mb = mb_n;
      if (rst) begin
         mb = 0;
         dd = 0;
         hold = 0;
         q.delete();
      end
   end
   int rcnt = 0, stall = 0, ready_mode = 0;
   always @(posedge clk) begin
      #1;
      rcnt++;
      if (ready_mode == 0) out_ready = 1'b1;
      else if (stall > 0) begin
         out_ready = 1'b0;
         stall--;
      end else if (rcnt % 150 == 0) begin
         out_ready = 1'b0;
         stall = 19;
      end else out_ready = 1'($urandom_range(0, 1));
   end
   task automatic pulse_start(input int nb);
      @(posedge clk);
      #1 start = 1'b1;
      num_bins = (BIN_W + 1)'(nb);
      @(posedge clk);
      #1 start = 1'b0;
   endtask
   task automatic wait_done(input string name, input int budget);
      int k = 0;
      while (done !== 1'b1 && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (done !== 1'b1) begin
         tests++;
         fails++;
         $display("FAIL %s_timeout: got no done expected done within %0d cycles", name, budget);
      end
      @(posedge clk);
      #1;
   endtask
   task automatic wait_xfers(input string name, input int n);
      int k = 0;
      while (xfers < n && k < 5000) begin
         @(negedge clk);
         k++;
      end
      if (xfers < n) begin
         tests++;
         fails++;
         $display("FAIL %s_timeout: got %0d words expected %0d", name, xfers, n);
      end
   endtask
   initial begin
      int d0, r0, v0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_rd_addr", rd_addr, 0);
      chk("rst_rd_en", rd_en, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_bin_last", out_bin_last, 0);
      chk("rst_last", out_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      check_on = 1;
      pulse_start(2);
      wait_done("full", 10000);
      chk("full_words", xfers, 2 * (NPTS + H));
      chk("full_queue_empty", q.size(), 0);
      chk("full_latency", first_valid - start_cyc, RD_LAT + 2);
      chk("full_back_to_back", last_x - first_x, 2 * (NPTS + H) - 1);
      chk("w0_data", cap_d[H], 0);
      chk("w1022_bin_last", cap_bl[H + 1022], 0);
      chk("w1023_data", cap_d[H + 1023], 1023);
      chk("w1023_bin_last", cap_bl[H + 1023], 1);
      chk("w1023_last", cap_l[H + 1023], 0);
      chk("w1024_data", cap_d[2 * H + 1024], 1024);
      chk("w2047_data", cap_d[2 * H + 2047], 2047);
      chk("w2047_bin_last", cap_bl[2 * H + 2047], 1);
      chk("w2047_last", cap_l[2 * H + 2047], 1);
`ifdef SPEC_RD_HEADER_EN
      chk("hdr0_data", cap_d[0], 32'hA5A5_0000);
      chk("hdr0_bin_last", cap_bl[0], 0);
      chk("hdr1_data", cap_d[1025], 32'hA5A5_0001);
      chk("hdr1_last", cap_l[1025], 0);
`endif
      ready_mode = 1;
      pulse_start(1);
      wait_done("backpressure", 20000);
      chk("bp_words", xfers, NPTS + H);
      chk("bp_queue_empty", q.size(), 0);
      ready_mode = 0;
      r0 = rd_total;
      v0 = ov_total;
      d0 = dones;
      pulse_start(0);
      wait_done("zero", 10);
      repeat (4) @(negedge clk);
      chk("zero_rd_en", rd_total - r0, 0);
      chk("zero_out_valid", ov_total - v0, 0);
      chk("zero_dones", dones - d0, 1);
      d0 = dones;
      pulse_start(1);
      wait_xfers("restart", 500);
      pulse_start(1);
      wait_done("restart", 5000);
      repeat (5) @(negedge clk);
      chk("restart_words", xfers, NPTS + H);
      chk("restart_dones", dones - d0, 1);
      pulse_start(1);
      wait_xfers("midrst", 300);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_rd_en", rd_en, 0);
      chk("midrst_done", done, 0);
      rst = 1'b0;
      d0 = dones;
      repeat (10) @(negedge clk);
      chk("midrst_no_done", dones - d0, 0);
      pulse_start(1);
      wait_done("after_rst", 5000);
      chk("after_rst_words", xfers, NPTS + H);
      chk("after_rst_w0", cap_d[H], 0);
      chk("after_rst_last", cap_l[H + NPTS - 1], 1);
      pulse_start(20);
      wait_done("clamp", 40000);
      chk("clamp_words", xfers, 16 * (NPTS + H));
      chk("clamp_queue_empty", q.size(), 0);
      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
